slave_responder: RTL and testbench
==================================

# slave_responder

Memory-backed responder for the crossbar slave-side request/ack interface. Sits behind one crossbar slave port (slave 0 or slave 1) and serves single-word reads and writes with a programmable acknowledge latency. Used as the endpoint model in crossbar system benches and as a small scratchpad in synthesized builds. Transactions are strictly serialized: one outstanding request at a time.

## Interface
Parameters:
- DEPTH_LOG2, default 4: memory holds 2^DEPTH_LOG2 32-bit words.
- ACK_DELAY, default 2: wait cycles inserted between request capture and the ack pulse. Legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request valid from the crossbar; held high until ack.
- cmd  input  1  0 = read, 1 = write.
- addr  input  32  byte address. Word index = addr[DEPTH_LOG2+1:2]. addr[1:0] and bits above DEPTH_LOG2+1, including bit 31 (the slave select), are ignored.
- wdata  input  32  write data; valid with req when cmd=1.
- ack  output  1  registered one-cycle request-accept pulse.
- rdata  output  32  registered read data; held between read responses.

## Operation
- State machine: IDLE, WAIT, ACK.
- IDLE: at the edge where req=1, capture cmd, word index and wdata; load cnt with ACK_DELAY. Go to ACK if ACK_DELAY=0, otherwise WAIT.
- WAIT: decrement cnt each cycle. When cnt reaches 1 and req=1, go to ACK.
- Abort: if req=0 while in WAIT (protocol violation), return to IDLE. No ack, no write, rdata unchanged.
- ACK: ack=1 for exactly this cycle; return to IDLE.
  - Write: mem[index] <= captured wdata at the edge ending the ACK cycle.
  - Read: rdata <= mem[index] at the same edge.
- Inputs are captured only in IDLE. Changes on cmd, addr or wdata after capture are ignored.
- cnt width is 4 bits. The counter never wraps because it is reloaded on every capture.
- Memory array is not reset. Its contents survive rst. A read of a never-written word returns X in simulation.
- Write transactions leave rdata unchanged.

## Timing
- Reset values: ack=0, rdata=32'h0, state=IDLE, cnt=0. rst asserted mid-transaction returns to IDLE immediately; a pending write is dropped.
- Cycle 0 is the cycle req is first high in IDLE (captured at its closing edge).
- ack is high during cycle 1+ACK_DELAY.
- Read data is valid on rdata from cycle 2+ACK_DELAY and stays until the next read ACK edge.
- Back-to-back: req may stay high in the cycle after ack for the next transaction. That cycle is IDLE and captures it. Sustained throughput is one transaction per ACK_DELAY+2 cycles.
- ack is never asserted in two consecutive cycles. ack is never asserted while req=0 at capture.

## Test plan
- Reset: assert rst mid-WAIT. Required: ack=0 and rdata=0 immediately. After release, no ack appears without a new req.
- Write then read, ACK_DELAY=2: write 32'hDEADBEEF to addr 32'h0000_0008. Required: ack in cycle 3. Then read addr 32'h8000_0008 (bit 31 ignored). Required: ack in cycle 3 of that transaction, rdata=32'hDEADBEEF from cycle 4, held afterward.
- ACK_DELAY=0, back-to-back, req held high: write A to word 1, write B to word 2, read word 1, read word 2. Required: ack every second cycle; rdata=A, then B, each appearing one cycle after its ack.
- Abort: with ACK_DELAY=3, drop req in cycle 2 during a write of 32'h1234 to word 5. Required: no ack, and word 5 keeps its prior value, confirmed by a later read.
- Address aliasing, DEPTH_LOG2=4: write 32'hA5A5A5A5 to addr 32'h0000_0044. Required: a read of addr 32'h0000_0004 returns 32'hA5A5A5A5 (index 1), and addr[1:0]=2'b11 gives the same result.
- Field stability: change cmd, addr and wdata during WAIT. Required: the transaction uses only the values captured in cycle 0.

Source files
------------

// File: rtl/slave_responder.sv
// slave_responder: single-word memory endpoint for a crossbar slave port with programmable ack latency.
module slave_responder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int ACK_DELAY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  cmd_q;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           wdata_q;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic                  unused_addr;

    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    // ack is registered alongside the transition into ACK so it is a clean flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            rdata   <= 32'h0;
            cmd_q   <= 1'b0;
            idx     <= '0;
            wdata_q <= 32'h0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    cmd_q   <= cmd;
                    idx     <= addr[DEPTH_LOG2+1:2];
                    wdata_q <= wdata;
                    cnt     <= 4'(ACK_DELAY);
                    state   <= (ACK_DELAY == 0) ? ACK : WAIT;
                    ack     <= (ACK_DELAY == 0);
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    if (!cmd_q) rdata <= mem[idx];
                end
                default: state <= IDLE;
            endcase
        end
    end

    // storage is deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (state == ACK && cmd_q) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_slave_responder.sv
// tb_slave_responder: directed checks of slave_responder at ACK_DELAY 2, 0 and 3.
module tb_slave_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [3];
    logic        cmd   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    slave_responder #(.DEPTH_LOG2(4), .ACK_DELAY(2)) u_d2 (
        .clk(clk), .rst(rst), .req(req[0]), .cmd(cmd[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]));
    slave_responder #(.DEPTH_LOG2(4), .ACK_DELAY(0)) u_d0 (
        .clk(clk), .rst(rst), .req(req[1]), .cmd(cmd[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]));
    slave_responder #(.DEPTH_LOG2(4), .ACK_DELAY(3)) u_d3 (
        .clk(clk), .rst(rst), .req(req[2]), .cmd(cmd[2]), .addr(addr[2]),
        .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]));

    typedef struct {
        logic        c;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one complete transaction; checks ack latency and that ack is a single pulse
    task automatic xact(input int k, input int dly, input logic c, input logic [31:0] a,
                        input logic [31:0] d, input string name, output logic [31:0] rd);
        int n = 0;
        @(negedge clk);
        req[k] = 1'b1; cmd[k] = c; addr[k] = a; wdata[k] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[k] && n < 20);
        req[k] = 1'b0;
        chk({name, "_lat"}, 32'(n), 32'(dly + 1));
        @(negedge clk);
        chk({name, "_pulse"}, {31'h0, ack[k]}, 32'h0);
        rd = rdata[k];
    endtask

    task automatic quiet(input int k, input int n, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen |= ack[k];
        end
        chk(name, {31'h0, seen}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        bc [4];
        logic [31:0] ba [4];
        logic [31:0] bd [4];
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; cmd[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        tbl[0] = '{1'b1, 32'h0000_0008, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 32'h8000_0008, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 32'h0000_0044, 32'hA5A5A5A5, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 32'h0000_0004, 32'h0,        32'hA5A5A5A5};
        tbl[4] = '{1'b1, 32'h0000_003C, 32'h11111111, 32'hA5A5A5A5};
        tbl[5] = '{1'b0, 32'h0000_003F, 32'h0,        32'h11111111};
        tbl[6] = '{1'b0, 32'h0000_0007, 32'h0,        32'hA5A5A5A5};
        tbl[7] = '{1'b0, 32'h0000_0008, 32'h0,        32'hDEADBEEF};
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_ack%0d", k), {31'h0, ack[k]}, 32'h0);
            chk($sformatf("reset_rdata%0d", k), rdata[k], 32'h0);
        end
        rst = 1'b0;

        // table-driven transactions on the ACK_DELAY=2 instance
        for (int i = 0; i < 8; i++) begin
            xact(0, 2, tbl[i].c, tbl[i].a, tbl[i].d, $sformatf("row%0d", i), rd);
            chk($sformatf("row%0d_rdata", i), rd, tbl[i].exp);
        end
        repeat (3) @(negedge clk);
        chk("rdata_hold", rdata[0], 32'hDEADBEEF);

        // reset mid-WAIT drops the pending write
        @(negedge clk);
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h0000_0BAD;
        @(negedge clk);
        rst = 1'b1; req[0] = 1'b0;
        #1;
        chk("rst_ack", {31'h0, ack[0]}, 32'h0);
        chk("rst_rdata", rdata[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        quiet(0, 6, "rst_no_ack");
        xact(0, 2, 1'b0, 32'h8, 32'h0, "rst_read", rd);
        chk("rst_write_dropped", rd, 32'hDEADBEEF);

        // inputs changed during WAIT must not affect the captured write
        xact(0, 2, 1'b1, 32'h1C, 32'h77, "stab_pre", rd);
        @(negedge clk);
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h18; wdata[0] = 32'h600D;
        @(negedge clk);
        cmd[0] = 1'b0; addr[0] = 32'h1C; wdata[0] = 32'hBAD0;
        @(negedge clk);
        chk("stab_c2_ack", {31'h0, ack[0]}, 32'h0);
        addr[0] = 32'h0; wdata[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stab_c3_ack", {31'h0, ack[0]}, 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        chk("stab_rdata_kept", rdata[0], 32'hDEADBEEF);
        xact(0, 2, 1'b0, 32'h18, 32'h0, "stab_rd18", rd);
        chk("stab_word6", rd, 32'h600D);
        xact(0, 2, 1'b0, 32'h1C, 32'h0, "stab_rd1c", rd);
        chk("stab_word7", rd, 32'h77);

        // ACK_DELAY=0 back-to-back with req held high
        bc[0] = 1'b1; ba[0] = 32'h4; bd[0] = 32'hAAAA0001;
        bc[1] = 1'b1; ba[1] = 32'h8; bd[1] = 32'hBBBB0002;
        bc[2] = 1'b0; ba[2] = 32'h4; bd[2] = 32'h0;
        bc[3] = 1'b0; ba[3] = 32'h8; bd[3] = 32'h0;
        @(negedge clk);
        req[1] = 1'b1; cmd[1] = bc[0]; addr[1] = ba[0]; wdata[1] = bd[0];
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack_t%0d", t), {31'h0, ack[1]}, {31'h0, t % 2 == 1});
            if (t == 4) chk("b2b_rdata_t4", rdata[1], 32'h0);
            if (t == 6) chk("b2b_rdata_t6", rdata[1], 32'hAAAA0001);
            if (t == 8) chk("b2b_rdata_t8", rdata[1], 32'hBBBB0002);
            if (t == 7) req[1] = 1'b0;
            else if (t % 2 == 1) begin
                cmd[1] = bc[(t + 1) / 2]; addr[1] = ba[(t + 1) / 2]; wdata[1] = bd[(t + 1) / 2];
            end
        end

        // ACK_DELAY=3 abort leaves memory untouched
        xact(2, 3, 1'b1, 32'h14, 32'h5555, "abort_pre", rd);
        @(negedge clk);
        req[2] = 1'b1; cmd[2] = 1'b1; addr[2] = 32'h14; wdata[2] = 32'h1234;
        @(negedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        quiet(2, 6, "abort_no_ack");
        xact(2, 3, 1'b0, 32'h14, 32'h0, "abort_read", rd);
        chk("abort_word5", rd, 32'h5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
